// File: rtl/servo_pkg.sv
// Shared widths, frame constants and types for the servo PWM generator.
// PWM_W sets the frame length (2^PWM_W ticks); DIV_W sets the prescaler range.
package servo_pkg;

    localparam int PWM_W = 8;
    localparam int DIV_W = 16;
    localparam int SERVO_FRAME_TICKS = 1 << PWM_W;

    typedef logic [PWM_W-1:0] duty_t;
    typedef logic [DIV_W-1:0] div_t;

    // Last tick index of a frame; a tick here rolls the frame over.
    localparam duty_t FRAME_LAST = duty_t'(SERVO_FRAME_TICKS - 1);

endpackage

// File: rtl/servo_tick_div.sv
// Prescaler: emits a one-clock tick every max(divClk,1) clocks.
// Ports: clk, resetb (async, active-high), divClk (clocks per tick), tick.
module servo_tick_div
    import servo_pkg::*;
(
    input  logic             clk,
    input  logic             resetb,
    input  logic [DIV_W-1:0] divClk,
    output logic             tick
);

    div_t cnt;
    div_t last;

    // divClk of 0 behaves as 1: wrap on every clock.
    assign last = (divClk == '0) ? '0 : divClk - div_t'(1);

    // >= rather than == so a divisor lowered below the current count
    // wraps on the next clock instead of running the counter round.
    assign tick = (cnt >= last);

    always_ff @(posedge clk or posedge resetb) begin
        if (resetb) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + div_t'(1);
        end
    end

endmodule

// File: rtl/servo_pwm_gen.sv
// Hobby-servo PWM: 2^PWM_W ticks per frame, pwm high for setPwm ticks.
// Ports: clk, resetb (async, active-high), setPwm, divClk, pwm (registered).
module servo_pwm_gen
    import servo_pkg::*;
(
    input  logic             clk,
    input  logic             resetb,
    input  logic [PWM_W-1:0] setPwm,
    input  logic [DIV_W-1:0] divClk,
    output logic             pwm
);

    logic  tick;
    logic  first;
    logic  frame_end;
    duty_t frame_cnt;
    duty_t duty_q;
    duty_t duty_eff;

    servo_tick_div u_div (
        .clk    (clk),
        .resetb (resetb),
        .divClk (divClk),
        .tick   (tick)
    );

    assign frame_end = tick && (frame_cnt == FRAME_LAST);

    // On the first clock after reset the latch is still loading, so
    // compare against setPwm directly to give that frame a full pulse.
    assign duty_eff = first ? setPwm : duty_q;

    always_ff @(posedge clk or posedge resetb) begin
        if (resetb) begin
            frame_cnt <= '0;
            duty_q    <= '0;
            first     <= 1'b1;
            pwm       <= 1'b0;
        end else begin
            first <= 1'b0;
            if (tick) begin
                frame_cnt <= frame_cnt + duty_t'(1);
            end
            // Duty only moves at a frame boundary: no runt pulses.
            if (first || frame_end) begin
                duty_q <= setPwm;
            end
            pwm <= (frame_cnt < duty_eff);
        end
    end

endmodule

// File: tb/tb_servo_pwm_gen.sv
// Scoreboard bench for servo_pwm_gen: expected pwm run lengths are queued
// by the stimulus and a negedge monitor compares each completed run.
module tb_servo_pwm_gen;

    typedef struct {
        bit    lvl;
        int    len;
        string name;
    } seg_t;

    logic        clk = 1'b0;
    logic        resetb;
    logic [7:0]  setPwm;
    logic [15:0] divClk;
    logic        pwm;

    int   checks = 0;
    int   errors = 0;
    seg_t exp_q[$];

    servo_pwm_gen dut (
        .clk    (clk),
        .resetb (resetb),
        .setPwm (setPwm),
        .divClk (divClk),
        .pwm    (pwm)
    );

    always #5 clk = ~clk;

    // Monitor: measure completed runs of pwm in clocks.
    bit mfresh = 1'b1;
    bit cur    = 1'b0;
    int run    = 0;

    always @(negedge clk) begin
        if (resetb) begin
            mfresh = 1'b1;
            cur    = 1'b0;
            run    = 0;
        end else if (pwm !== cur) begin
            if (!mfresh && exp_q.size() > 0) begin
                seg_t e;
                e = exp_q.pop_front();
                checks++;
                if (cur !== e.lvl || run != e.len) begin
                    errors++;
                    $display("FAIL %s: got level=%0b len=%0d, want level=%0b len=%0d",
                             e.name, cur, run, e.lvl, e.len);
                end
            end
            mfresh = 1'b0;
            cur    = pwm;
            run    = 1;
        end else begin
            run++;
        end
    end

    task automatic expect_seg(input bit lvl, input int len, input string name);
        seg_t e;
        e.lvl  = lvl;
        e.len  = len;
        e.name = name;
        exp_q.push_back(e);
    endtask

    task automatic check_bit(input string name, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %b, want %b", name, got, want);
        end
    endtask

    task automatic drain(input string name, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (exp_q.size() == 0) return;
            @(posedge clk);
        end
        checks++;
        errors++;
        $display("FAIL %s: timeout, %0d runs still expected, want 0",
                 name, exp_q.size());
        exp_q.delete();
    endtask

    // Hold reset a few clocks with new settings, check pwm, release.
    task automatic restart(input logic [15:0] d, input logic [7:0] p);
        @(posedge clk);
        #2;
        resetb = 1'b1;
        divClk = d;
        setPwm = p;
        repeat (3) @(posedge clk);
        #2;
        check_bit("reset_hold", pwm, 1'b0);
        resetb = 1'b0;
    endtask

    initial begin
        int highs;
        resetb = 1'b1;
        setPwm = '0;
        divClk = '0;

        // Basic frame: div 4, duty 3 -> 12 high / 1012 low.
        expect_seg(1'b1, 12, "d4_high0");
        expect_seg(1'b0, 1012, "d4_low0");
        expect_seg(1'b1, 12, "d4_high1");
        expect_seg(1'b0, 1012, "d4_low1");
        restart(16'd4, 8'd3);
        drain("d4", 2400);

        // Mid-frame duty change is deferred to the next frame.
        expect_seg(1'b1, 192, "chg_high0");
        expect_seg(1'b0, 576, "chg_low0");
        expect_seg(1'b1, 192, "chg_high1");
        expect_seg(1'b0, 576, "chg_low1");
        expect_seg(1'b1, 384, "chg_high2");
        expect_seg(1'b0, 384, "chg_low2");
        restart(16'd3, 8'h40);
        repeat (800) @(posedge clk);
        #2;
        setPwm = 8'h80;
        drain("chg", 2500);

        // Duty 0: pwm never rises over three frames.
        restart(16'd1, 8'd0);
        highs = 0;
        repeat (3 * 256 + 8) begin
            @(negedge clk);
            if (pwm) highs++;
        end
        checks++;
        if (highs != 0) begin
            errors++;
            $display("FAIL duty0: got %0d high clocks, want 0", highs);
        end

        // Duty 255, div 2: 510 high / 2 low.
        expect_seg(1'b1, 510, "d255_high0");
        expect_seg(1'b0, 2, "d255_low0");
        expect_seg(1'b1, 510, "d255_high1");
        expect_seg(1'b0, 2, "d255_low1");
        restart(16'd2, 8'd255);
        drain("d255", 1500);

        // divClk 0 and 1 both tick every clock.
        expect_seg(1'b1, 10, "div0_high0");
        expect_seg(1'b0, 246, "div0_low0");
        expect_seg(1'b1, 10, "div0_high1");
        expect_seg(1'b0, 246, "div0_low1");
        restart(16'd0, 8'd10);
        drain("div0", 800);

        expect_seg(1'b1, 10, "div1_high0");
        expect_seg(1'b0, 246, "div1_low0");
        expect_seg(1'b1, 10, "div1_high1");
        expect_seg(1'b0, 246, "div1_low1");
        restart(16'd1, 8'd10);
        drain("div1", 800);

        // Reset mid-pulse at tick 50: async drop, then a full fresh pulse.
        restart(16'd4, 8'd100);
        repeat (200) @(posedge clk);
        #2;
        check_bit("pre_reset_high", pwm, 1'b1);
        resetb = 1'b1;
        #1;
        check_bit("async_drop", pwm, 1'b0);
        repeat (2) @(posedge clk);
        #2;
        check_bit("reset_held", pwm, 1'b0);
        expect_seg(1'b1, 400, "rel_high");
        expect_seg(1'b0, 624, "rel_low");
        resetb = 1'b0;
        drain("rel", 1400);

        // Divisor lowered 1000 -> 5 at prescaler 700: wraps at once.
        expect_seg(1'b1, 701, "lower_high0");
        expect_seg(1'b0, 1275, "lower_low0");
        expect_seg(1'b1, 5, "lower_high1");
        restart(16'd1000, 8'd1);
        repeat (700) @(posedge clk);
        #2;
        divClk = 16'd5;
        drain("lower", 3000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
